// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, feeding IF/ID. Rev 1.0.
// Optional macro FETCH_MISALIGN_EXC_EN enables the misaligned-PC FAULT state.
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_1000,
    parameter logic [31:0] EXC_HANDLER_PC = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_stall,
    input  logic        in_d_cache_stall,
    input  logic        in_branch_taken,
    input  logic [31:0] in_branch_target,
    input  logic        in_exception_redirect,
    output logic        out_icache_req,
    output logic [31:0] out_icache_addr,
    input  logic        in_icache_valid,
    input  logic [31:0] in_icache_data,
    output logic [31:0] out_instruction,
    output logic [31:0] out_PC,
    output logic [2:0]  out_exception_vector,
    output logic        out_i_cache_stall
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_HOLD  = 3'd2,
`ifdef FETCH_MISALIGN_EXC_EN
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
`else
        S_DRAIN = 3'd3
`endif
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc_q;

    logic        w_hold;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_misaligned;

    assign w_hold     = in_stall | in_d_cache_stall;
    assign w_redirect = in_exception_redirect | in_branch_taken;
    assign w_target   = in_exception_redirect ? EXC_HANDLER_PC : in_branch_target;

`ifdef FETCH_MISALIGN_EXC_EN
    assign w_misaligned = (pc_q[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    if (w_misaligned) begin
                        // A misaligned PC never reaches the cache; a redirect can still rescue it.
                        if (w_redirect) begin
                            pc_q <= w_target;
                        end else begin
`ifdef FETCH_MISALIGN_EXC_EN
                            state_q <= S_FAULT;
`else
                            state_q <= S_REQ;
`endif
                        end
                    end else if (in_icache_valid) begin
                        if (w_redirect) begin
                            pc_q <= w_target;
                        end else if (w_hold) begin
                            hold_instr_q <= in_icache_data;
                            hold_pc_q    <= pc_q;
                            state_q      <= S_HOLD;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end else if (w_redirect) begin
                        pc_q    <= w_target;
                        state_q <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        pc_q    <= w_target;
                        state_q <= S_REQ;
                    end else if (!w_hold) begin
                        pc_q    <= hold_pc_q + 32'd4;
                        state_q <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (w_redirect) pc_q <= w_target;
                    if (in_icache_valid) state_q <= S_REQ;
                end
`ifdef FETCH_MISALIGN_EXC_EN
                S_FAULT: begin
                    if (w_redirect) begin
                        pc_q    <= w_target;
                        state_q <= S_REQ;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        out_icache_req       = 1'b0;
        out_icache_addr      = 32'h0;
        out_instruction      = 32'h0;
        out_PC               = 32'h0;
        out_exception_vector = 3'b000;
        out_i_cache_stall    = 1'b0;
        case (state_q)
            S_REQ: begin
                if (!w_misaligned) begin
                    out_icache_req  = 1'b1;
`ifdef FETCH_MISALIGN_EXC_EN
                    out_icache_addr = pc_q;
`else
                    out_icache_addr = {pc_q[31:2], 2'b00};
`endif
                    if (in_icache_valid) begin
                        out_instruction = in_icache_data;
                        out_PC          = pc_q;
                    end else begin
                        out_i_cache_stall = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                out_instruction = hold_instr_q;
                out_PC          = hold_pc_q;
            end
            S_DRAIN: out_i_cache_stall = 1'b1;
`ifdef FETCH_MISALIGN_EXC_EN
            S_FAULT: begin
                out_PC               = pc_q;
                out_exception_vector = 3'b001;
            end
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire
